// File: rtl/c5efa7_fpga_bup_ram_loader_pkg.sv
// Shared definitions for the byte-stream to 32-bit RAM loader:
// state encoding, lane geometry and the default address width.
package c5efa7_fpga_bup_ram_loader_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = $clog2(LANES);
  localparam int ADDR_W_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

endpackage

// File: rtl/c5efa7_fpga_bup_ram_loader_if.sv
// Byte-stream input plus RAM write port of the loader. The master drives
// the stream and observes the RAM port; the slave is the loader itself.
interface c5efa7_fpga_bup_ram_loader_if
  import c5efa7_fpga_bup_ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_eop;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic              ram_clken;

  modport master (
    output in_valid, in_data, in_eop,
    input  in_ready, ram_address, ram_chipselect, ram_write,
           ram_byteenable, ram_writedata, ram_clken
  );

  modport slave (
    input  in_valid, in_data, in_eop,
    output in_ready, ram_address, ram_chipselect, ram_write,
           ram_byteenable, ram_writedata, ram_clken
  );
endinterface

// File: rtl/c5efa7_fpga_bup_byte_packer.sv
// Little-endian byte-to-word packer. word_o/be_o already include the byte
// being accepted this cycle, so the caller can register a complete word.
module c5efa7_fpga_bup_byte_packer
  import c5efa7_fpga_bup_ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              flush_i,
  input  logic [7:0]        byte_i,
  output logic [LANE_W-1:0] lane_o,
  output logic [31:0]       word_o,
  output logic [LANES-1:0]  be_o
);
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       data_q, data_d;
  logic [LANES-1:0]  be_q, be_d;

  assign lane_o = lane_q;

  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    word_o = data_q;
    be_o   = be_q;
    if (accept_i) begin
      word_o[{lane_q, 3'b000} +: 8] = byte_i;
      be_o[lane_q]                  = 1'b1;
    end

    lane_d = lane_q;
    data_d = data_q;
    be_d   = be_q;
    if (clear_i) begin
      lane_d = '0;
      data_d = '0;
      be_d   = '0;
    end else if (accept_i) begin
      lane_d = lane_q + LANE_W'(1);
      // A flushed word leaves the holding register empty so the next byte
      // can be taken in the same cycle the write goes out.
      data_d = flush_i ? '0 : word_o;
      be_d   = flush_i ? '0 : be_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end

endmodule

// File: rtl/c5efa7_fpga_bup_ram_loader.sv
// Loads a byte stream into a 32-bit-word RAM starting at start_word,
// writing each completed or final partial word the cycle after it fills.
module c5efa7_fpga_bup_ram_loader
  import c5efa7_fpga_bup_ram_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WORD = 131071
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_word,
  c5efa7_fpga_bup_ram_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_W+1:0]    byte_count
);
  localparam logic [ADDR_W:0] MAX_PTR = (ADDR_W+1)'(MAX_WORD);

  state_e            state_q;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W+1:0] byte_count_q;
  logic              in_ready_q, busy_q, done_q, ovf_q, ram_write_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [3:0]        ram_be_q;
  logic [31:0]       ram_wd_q;

  logic              accept, ovf_hit, take, word_end, start_ok;
  logic [LANE_W-1:0] lane;
  logic [31:0]       pk_word;
  logic [LANES-1:0]  pk_be;

  // in_ready is only ever high in LOAD, so an accept implies LOAD.
  assign accept   = bus.in_valid && in_ready_q;
  assign ovf_hit  = accept && (lane == '0) && (ptr_q > MAX_PTR);
  assign take     = accept && !ovf_hit;
  assign word_end = take && ((lane == LANE_W'(LANES-1)) || bus.in_eop);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

  c5efa7_fpga_bup_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (start_ok),
    .accept_i(take),
    .flush_i (word_end),
    .byte_i  (bus.in_data),
    .lane_o  (lane),
    .word_o  (pk_word),
    .be_o    (pk_be)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      byte_count_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_be_q     <= '0;
      ram_wd_q     <= '0;
    end else begin
      ram_write_q <= 1'b0;
      done_q      <= 1'b0;
      if (take) byte_count_q <= byte_count_q + (ADDR_W+2)'(1);
      if (word_end) begin
        ram_write_q <= 1'b1;
        ram_addr_q  <= ptr_q[ADDR_W-1:0];
        ram_be_q    <= pk_be;
        ram_wd_q    <= pk_word;
        ptr_q       <= ptr_q + (ADDR_W+1)'(1);
      end
      unique case (state_q)
        ST_IDLE, ST_ERR: if (start_ok) begin
          state_q      <= ST_LOAD;
          ptr_q        <= {1'b0, start_word};
          byte_count_q <= '0;
          ovf_q        <= 1'b0;
          in_ready_q   <= 1'b1;
          busy_q       <= 1'b1;
        end
        ST_LOAD: if (ovf_hit) begin
          state_q    <= ST_ERR;
          ovf_q      <= 1'b1;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end else if (take && bus.in_eop) begin
          state_q    <= ST_FLUSH;
          in_ready_q <= 1'b0;
          done_q     <= 1'b1;
        end
        ST_FLUSH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.ram_address    = ram_addr_q;
  assign bus.ram_chipselect = ram_write_q;
  assign bus.ram_write      = ram_write_q;
  assign bus.ram_byteenable = ram_be_q;
  assign bus.ram_writedata  = ram_wd_q;
  assign bus.ram_clken      = 1'b1;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overflow           = ovf_q;
  assign byte_count         = byte_count_q;

endmodule

// File: tb/tb_c5efa7_fpga_bup_ram_loader.sv
// Directed bench for the RAM loader: captured RAM writes are compared
// against hand-computed words, addresses and enables.
module tb_c5efa7_fpga_bup_ram_loader;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_word;
  logic              busy, done, overflow;
  logic [ADDR_W+1:0] byte_count;

  c5efa7_fpga_bup_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  c5efa7_fpga_bup_ram_loader #(.ADDR_W(ADDR_W), .MAX_WORD(131071)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_word(start_word),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       d;
    logic              dn;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  checks   = 0;
  int  errors   = 0;

  always @(negedge clk) begin
    if (bus.ram_write === 1'b1)
      wq.push_back('{a: bus.ram_address, be: bus.ram_byteenable,
                     d: bus.ram_writedata, dn: done});
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic dn);
    check({tag, "_present"}, 64'(idx < wq.size()), 64'd1);
    if (idx < wq.size()) begin
      check({tag, "_addr"}, 64'(wq[idx].a), 64'(a));
      check({tag, "_be"},   64'(wq[idx].be), 64'(be));
      check({tag, "_data"}, 64'(wq[idx].d), 64'(d));
      check({tag, "_done"}, 64'(wq[idx].dn), 64'(dn));
    end
  endtask

  task automatic new_test();
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] w);
    @(negedge clk);
    start      = 1'b1;
    start_word = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input logic eop);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_eop   = eop;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_write"},    64'(bus.ram_write), 64'd0);
    check({tag, "_cs"},       64'(bus.ram_chipselect), 64'd0);
    check({tag, "_be"},       64'(bus.ram_byteenable), 64'd0);
    check({tag, "_wdata"},    64'(bus.ram_writedata), 64'd0);
    check({tag, "_addr"},     64'(bus.ram_address), 64'd0);
    check({tag, "_busy"},     64'(busy), 64'd0);
    check({tag, "_done"},     64'(done), 64'd0);
    check({tag, "_ovf"},      64'(overflow), 64'd0);
    check({tag, "_bcount"},   64'(byte_count), 64'd0);
    check({tag, "_clken"},    64'(bus.ram_clken), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[40];
    logic [7:0] seq1[5];

    reset        = 1'b1;
    start        = 1'b0;
    start_word   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_eop   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Two full words, done on the second write.
    new_test();
    do_start(17'h00010);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    repeat (3) @(negedge clk);
    check("t1_nwr", 64'(wq.size()), 64'd2);
    check_wr("t1_w0", 0, 17'h10, 4'hF, 32'h04030201, 1'b0);
    check_wr("t1_w1", 1, 17'h11, 4'hF, 32'h08070605, 1'b1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_bcount", 64'(byte_count), 64'd8);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Partial final word: only lane 0 enabled.
    new_test();
    seq1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_start(17'h00000);
    for (int i = 0; i < 5; i++) send_byte(seq1[i], i == 4);
    repeat (3) @(negedge clk);
    check("t2_nwr", 64'(wq.size()), 64'd2);
    check_wr("t2_w0", 0, 17'h0, 4'hF, 32'hDDCCBBAA, 1'b0);
    check_wr("t2_w1", 1, 17'h1, 4'h1, 32'h000000EE, 1'b1);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_bcount", 64'(byte_count), 64'd5);

    // Overflow past the last word.
    new_test();
    do_start(17'h1FFFF);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b0);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_ready", 64'(bus.in_ready), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_state", 64'(dut.state_q), 64'(2'd3));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_nwr", 64'(wq.size()), 64'd1);
    check_wr("t3_w0", 0, 17'h1FFFF, 4'hF, 32'h13121110, 1'b0);
    check("t3_done_cnt", 64'(done_cnt), 64'd0);
    do_start(17'h00020);
    check("t3_ovf_clr", 64'(overflow), 64'd0);
    check("t3_ready2", 64'(bus.in_ready), 64'd1);
    send_byte(8'h33, 1'b1);
    repeat (2) @(negedge clk);
    check_wr("t3_w1", 1, 17'h20, 4'h1, 32'h00000033, 1'b1);

    // Random valid gaps against a packing model.
    new_test();
    for (int i = 0; i < 40; i++) rb[i] = 8'(i * 37 + 5);
    do_start(17'h00100);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) @(negedge clk);
      send_byte(rb[i], i == 39);
    end
    repeat (3) @(negedge clk);
    check("t4_nwr", 64'(wq.size()), 64'd10);
    for (int k = 0; k < 10; k++)
      check_wr($sformatf("t4_w%0d", k), k, 17'(17'h100 + k), 4'hF,
               {rb[4*k+3], rb[4*k+2], rb[4*k+1], rb[4*k]}, k == 9);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_bcount", 64'(byte_count), 64'd40);

    // start during LOAD is ignored.
    new_test();
    do_start(17'h00040);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_start(17'h00077);
    check("t5_bcount_mid", 64'(byte_count), 64'd2);
    check("t5_busy_mid", 64'(busy), 64'd1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_nwr", 64'(wq.size()), 64'd1);
    check_wr("t5_w0", 0, 17'h40, 4'hF, 32'h44332211, 1'b1);
    check("t5_bcount", 64'(byte_count), 64'd4);

    // Reset mid-word abandons the partial word.
    new_test();
    do_start(17'h00050);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_nwr", 64'(wq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c5efa7_fpga_bup_ram_loader.md
C5EFA7_FPGA_BUP_RAM_LOADER -- requirements
Module: c5efa7_fpga_bup_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 17: RAM word-address width; the RAM is 2^ADDR_W words of 32 bits.
REQ-002 SHALL have parameter MAX_WORD, default 131071: last writable word address.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; also drives the RAM write port.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 start_word  in  ADDR_W  first word address of the load; sampled with start.
REQ-008 in_valid  in  1  byte-stream valid.
REQ-009 in_ready  out  1  byte-stream ready; a byte is accepted when in_valid and in_ready are both high.
REQ-010 in_data  in  8  stream byte.
REQ-011 in_eop  in  1  marks the last byte of the image; qualified by the accept.
REQ-012 ram_address  out  ADDR_W  RAM word address.
REQ-013 ram_chipselect  out  1  RAM select.
REQ-014 ram_write  out  1  RAM write strobe.
REQ-015 ram_byteenable  out  4  per-lane byte enables.
REQ-016 ram_writedata  out  32  packed write word.
REQ-017 ram_clken  out  1  RAM clock enable; constant 1.
REQ-018 busy  out  1  high in LOAD and FLUSH.
REQ-019 done  out  1  one-cycle pulse at a normal load end.
REQ-020 overflow  out  1  sticky error flag; cleared only by reset or an accepted start.
REQ-021 byte_count  out  ADDR_W+2  number of bytes accepted in the current or last load.

Function
REQ-022 SHALL implement the states IDLE, LOAD, FLUSH and ERR.
REQ-023 IDLE: in_ready=0; start moves to LOAD, loads word pointer=start_word, lane=0, byte_count=0, and clears overflow.
REQ-024 LOAD: in_ready=1 every cycle; each accepted byte goes into lane `lane` (byte 0 to bits 7:0, little-endian), sets that lane's enable bit, increments lane mod 4, and increments byte_count.
REQ-025 When the byte accepted in lane 3 arrives, or any byte arrives with in_eop, the next cycle SHALL drive exactly one write: ram_chipselect=ram_write=1, ram_address=pointer, byteenable=collected lanes, writedata=packed word.
REQ-026 After that write, the pointer SHALL increment and the lane enables SHALL clear; the next byte can be accepted in the same cycle as the write (full 1 byte/cycle throughput, no bubbles).
REQ-027 Unused lanes of a partial word SHALL be 0 in writedata and 0 in byteenable.
REQ-028 An accept with in_eop SHALL go to FLUSH; FLUSH drives the final write, pulses done, and returns to IDLE, so done coincides with the last write.
REQ-029 Overflow: an accept that would start a word beyond MAX_WORD (pointer wrapped past MAX_WORD) SHALL NOT write; set overflow, go to ERR. ERR: in_ready=0, no writes, and ERR stays until start, which behaves as in IDLE.
REQ-030 start while in LOAD or FLUSH SHALL be ignored.
REQ-031 in_eop with no data in flight is impossible by construction; eop always accompanies a byte.
REQ-032 ram_write/ram_chipselect SHALL be high for at most one cycle per word; there is no waitrequest and the RAM always accepts.
REQ-033 Pointer arithmetic SHALL be ADDR_W+1 bits wide to detect the wrap; ram_address carries the low ADDR_W bits.

Reset
REQ-034 Reset SHALL force state=IDLE, in_ready=0, ram_write=0, ram_chipselect=0, ram_byteenable=0, ram_writedata=0, ram_address=0, busy=0, done=0, overflow=0, byte_count=0.
REQ-035 Reset mid-load SHALL abandon any partial word without writing it; ram_clken stays 1 during reset.

Structure
REQ-036 A shared package SHALL hold the state encoding, the lane-count constant (4), and the ADDR_W default.
REQ-037 Byte packing SHALL live in one sub-module, c5efa7_fpga_bup_byte_packer (lane counter, holding register, enables); the top level holds the FSM, pointer and counters.

Verification
REQ-038 start, start_word=0x00010, stream bytes 01..08 back-to-back with eop on 08 -> writes 0x04030201@0x10 be=F, then 0x08070605@0x11 be=F; done pulses with the second write; byte_count=8.
REQ-039 start_word=0x00000, 5 bytes AA BB CC DD EE with eop on EE -> second write 0x000000EE@0x01 be=1; done pulses once.
REQ-040 start_word=0x1FFFF, 8 bytes -> one write at 0x1FFFF; the 5th byte is not written, overflow=1, state ERR, in_ready=0; a new start clears overflow.
REQ-041 in_valid toggled randomly 50% over 40 bytes -> word contents and addresses match a reference model; no duplicate or missing writes.
REQ-042 reset asserted after 2 bytes of a word -> no write occurs; all outputs match REQ-034 on the next cycle.
REQ-043 start pulsed during LOAD -> ignored; pointer and byte_count continue unchanged.
